// File: rtl/cpu_debug_jtag_scan_master.sv
// cpu_debug_jtag_scan_master
// Initiator for the CPU debug slave's virtual-JTAG interface. Each accepted
// command runs one complete scan, UIR -> CDR -> SDR -> UDR -> RTI, and then
// holds the captured data until the consumer takes it. Everything runs on clk.
// vji_tck is a divided clock produced as a registered data signal.
//
// Ports:
//   clk, reset           system clock; synchronous active-high reset
//   cmd_valid/ready      command handshake; cmd_ir = IR value,
//                        cmd_dr = DR data shifted out LSB first
//   rsp_valid/ready      response handshake; rsp_dr = captured tdo bits
//                        (bit i = i-th bit shifted out); rsp_ir_out = slave IR
//                        status sampled during UIR
//   vji_*                virtual-JTAG signals to and from the debug slave
module cpu_debug_jtag_scan_master #(
  parameter int DR_WIDTH   = 38,
  parameter int TCK_HALF   = 2,
  parameter int RTI_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [1:0]          rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [1:0]          vji_ir_in,
  input  logic [1:0]          vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int PH_W = (TCK_HALF > 1) ? $clog2(2 * TCK_HALF) : 1;
  localparam int BC_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam int RC_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

  // Phase at which tck rises (sampling point), and last phase of a period.
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(TCK_HALF - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * TCK_HALF - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DR_WIDTH - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UIR  = 3'd1,
    CDR  = 3'd2,
    SDR  = 3'd3,
    UDR  = 3'd4,
    RTI  = 3'd5,
    RESP = 3'd6
  } state_t;

  state_t              state;
  logic [PH_W-1:0]     ph;
  logic [BC_W-1:0]     bit_cnt;
  logic [RC_W-1:0]     rti_cnt;
  logic [DR_WIDTH-1:0] shift;
  logic [DR_WIDTH-1:0] capture;

  logic scanning;
  logic rise;
  logic period_end;

  assign scanning   = (state == UIR) || (state == CDR) || (state == SDR) ||
                      (state == UDR) || (state == RTI);
  assign rise       = (ph == PH_RISE);
  assign period_end = (ph == PH_LAST);

  // Scan sequencer: state, tck phase generation, shifting, capture and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ph         <= '0;
      bit_cnt    <= '0;
      rti_cnt    <= '0;
      shift      <= '0;
      capture    <= '0;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= 2'b00;
      vji_tck    <= 1'b0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= 2'b00;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b0;
    end else begin
      // Phase counter runs continuously through the scan states. Every state
      // spans whole periods, so it wraps to 0 exactly at each state boundary.
      if (scanning) begin
        ph <= period_end ? '0 : ph + PH_W'(1);
        if (rise) begin
          vji_tck <= 1'b1;
        end else if (period_end) begin
          vji_tck <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= UIR;
            cmd_ready <= 1'b0;
            shift     <= cmd_dr;
            vji_ir_in <= cmd_ir;
            vji_uir   <= 1'b1;
            ph        <= '0;
          end
        end
        UIR: begin
          if (rise) begin
            rsp_ir_out <= vji_ir_out;
          end
          if (period_end) begin
            vji_uir <= 1'b0;
            vji_cdr <= 1'b1;
            state   <= CDR;
          end
        end
        CDR: begin
          if (period_end) begin
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b1;
            vji_tdi <= shift[0];
            bit_cnt <= '0;
            state   <= SDR;
          end
        end
        SDR: begin
          if (rise) begin
            capture[bit_cnt] <= vji_tdo;
          end
          if (period_end) begin
            if (bit_cnt == BC_LAST) begin
              // Last bit already presented: leave without a further shift.
              vji_sdr <= 1'b0;
              vji_udr <= 1'b1;
              vji_tdi <= 1'b0;
              state   <= UDR;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
              shift   <= {1'b0, shift[DR_WIDTH-1:1]};
              vji_tdi <= shift[1];
            end
          end
        end
        UDR: begin
          if (period_end) begin
            vji_udr <= 1'b0;
            vji_rti <= 1'b1;
            rti_cnt <= '0;
            state   <= RTI;
          end
        end
        RTI: begin
          if (period_end) begin
            if (rti_cnt == RC_LAST) begin
              vji_rti   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_dr    <= capture;
              state     <= RESP;
            end else begin
              rti_cnt <= rti_cnt + RC_W'(1);
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle.
          state     <= IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          vji_tck   <= 1'b0;
          vji_tdi   <= 1'b0;
          vji_uir   <= 1'b0;
          vji_cdr   <= 1'b0;
          vji_sdr   <= 1'b0;
          vji_udr   <= 1'b0;
          vji_rti   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_jtag_scan_master.sv
// Self-checking bench for cpu_debug_jtag_scan_master: default instance (a)
// driven against a tdi->tdo loopback slave model, plus a small instance (b)
// with TCK_HALF=1, DR_WIDTH=4, RTI_CYCLES=2.
module tb_cpu_debug_jtag_scan_master;

  localparam logic [37:0] DR1 = 38'h2A_5555_AAAA;
  localparam logic [37:0] DR2 = 38'h3F_FFFF_0000;
  localparam logic [37:0] DR3 = 38'h15_F0F0_3C3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a signals
  logic        reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]  cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [37:0] cmd_dr, rsp_dr;
  logic        vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic        vji_tdo = 1'b0;

  // Instance b signals
  logic        reset_b, cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_ready_b;
  logic [1:0]  cmd_ir_b, rsp_ir_out_b, vji_ir_in_b, vji_ir_out_b;
  logic [3:0]  cmd_dr_b, rsp_dr_b;
  logic        tck_b, tdi_b, uir_b, cdr_b, sdr_b, udr_b, rti_b;
  logic        tdo_b = 1'b0;

  int passed = 0;
  int total  = 0;

  cpu_debug_jtag_scan_master dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  cpu_debug_jtag_scan_master #(.DR_WIDTH(4), .TCK_HALF(1), .RTI_CYCLES(2)) dut_b (
    .clk(clk), .reset(reset_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_ir(cmd_ir_b), .cmd_dr(cmd_dr_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_dr(rsp_dr_b), .rsp_ir_out(rsp_ir_out_b),
    .vji_tck(tck_b), .vji_tdi(tdi_b), .vji_tdo(tdo_b),
    .vji_ir_in(vji_ir_in_b), .vji_ir_out(vji_ir_out_b),
    .vji_uir(uir_b), .vji_cdr(cdr_b), .vji_sdr(sdr_b), .vji_udr(udr_b), .vji_rti(rti_b)
  );

  // Loopback slave models: tdo is tdi delayed by one tck rising edge.
  always @(posedge vji_tck) vji_tdo <= vji_tdi;
  always @(posedge tck_b)   tdo_b   <= tdi_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {uir,cdr,sdr,udr,rti} for default-parameter scan cycle c.
  function automatic logic [4:0] exp_strobes(input int c);
    if (c >= 1 && c <= 4)          return 5'b10000;
    else if (c >= 5 && c <= 8)     return 5'b01000;
    else if (c >= 9 && c <= 160)   return 5'b00100;
    else if (c >= 161 && c <= 164) return 5'b00010;
    else if (c >= 165 && c <= 168) return 5'b00001;
    else                           return 5'b00000;
  endfunction

  initial begin
    int bad;
    int bad_ir;
    int idx;
    int first;
    logic [3:0]  seq;
    logic [37:0] exp_dr;

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_ir = 2'b00; cmd_dr = '0;
    vji_ir_out = 2'b00;
    reset_b = 1'b1; cmd_valid_b = 1'b0; rsp_ready_b = 1'b0; cmd_ir_b = 2'b00;
    cmd_dr_b = 4'b0000; vji_ir_out_b = 2'b00;

    // Reset held 3 cycles
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (vji_tck !== 1'b0) bad++;
    end
    check("rst_tck", 64'(bad), 64'd0);
    check("rst_outs", 64'({vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
                           vji_ir_in, rsp_valid, rsp_ir_out}), 64'd0);
    check("rst_rsp_dr", 64'(rsp_dr), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    reset = 1'b0; reset_b = 1'b0;

    // rsp_ready with no response pending does nothing
    rsp_ready = 1'b1;
    tick();
    check("idle_rsp_ready", 64'({rsp_valid, cmd_ready}), 64'b01);
    rsp_ready = 1'b0;

    // Scan 1: loopback, ir_out=10 during UIR then changed
    vji_ir_out = 2'b10; cmd_ir = 2'b01; cmd_dr = DR1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    bad = 0; bad_ir = 0;
    for (int c = 1; c <= 168; c++) begin
      if (c == 5) vji_ir_out = 2'b01;
      if ({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== exp_strobes(c) ||
          rsp_valid !== 1'b0 || cmd_ready !== 1'b0) bad++;
      if (vji_ir_in !== 2'b01) bad_ir++;
      tick();
    end
    check("scan1_strobes", 64'(bad), 64'd0);
    check("scan1_ir_in", 64'(bad_ir), 64'd0);
    check("scan1_rsp_valid_169", 64'(rsp_valid), 64'd1);
    exp_dr = DR1 << 1;
    check("scan1_rsp_dr", 64'(rsp_dr), 64'(exp_dr));
    check("scan1_rsp_ir_out", 64'(rsp_ir_out), 64'b10);

    // Back-pressure with a second command waiting
    cmd_ir = 2'b11; cmd_dr = DR2; cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_dr !== exp_dr || vji_tck !== 1'b0) bad++;
      tick();
    end
    check("bp_hold", 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_after_hs", 64'({rsp_valid, cmd_ready, vji_uir}), 64'b010);
    tick();
    check("bp_second_start", 64'({vji_uir, vji_ir_in}), 64'b111);
    cmd_valid = 1'b0;

    // Reset in the middle of SDR (scan cycle 50)
    for (int c = 2; c <= 50; c++) tick();
    check("mid_sdr_active", 64'(vji_sdr), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_outs", 64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti,
                               rsp_valid, vji_ir_in}), 64'd0);
    check("rst_mid_ready", 64'(cmd_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid !== 1'b0) bad++;
      tick();
    end
    check("rst_mid_no_rsp", 64'(bad), 64'd0);

    // Fresh scan after the aborted one
    cmd_ir = 2'b10; cmd_dr = DR3; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    bad = 0;
    for (int c = 1; c <= 168; c++) begin
      if (rsp_valid !== 1'b0) bad++;
      tick();
    end
    check("scan3_no_early_rsp", 64'(bad), 64'd0);
    check("scan3_rsp_valid_169", 64'(rsp_valid), 64'd1);
    exp_dr = DR3 << 1;
    check("scan3_rsp_dr", 64'(rsp_dr), 64'(exp_dr));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("scan3_rsp_cleared", 64'({rsp_valid, cmd_ready}), 64'b01);

    // Instance b: TCK_HALF=1, DR_WIDTH=4, RTI_CYCLES=2
    cmd_ir_b = 2'b01; cmd_dr_b = 4'b1011; cmd_valid_b = 1'b1;
    tick();
    cmd_valid_b = 1'b0;
    idx = 0; first = 0; seq = 4'b0000;
    for (int c = 1; c <= 19; c++) begin
      if (sdr_b === 1'b1 && tck_b === 1'b1 && idx < 4) begin
        seq[idx] = tdi_b;
        idx++;
      end
      if (rsp_valid_b === 1'b1 && first == 0) first = c;
      if (c < 19) tick();
    end
    check("b_tdi_count", 64'(idx), 64'd4);
    check("b_tdi_seq", 64'(seq), 64'b1011);
    check("b_rsp_cycle", 64'(first), 64'd19);
    check("b_rsp_dr", 64'(rsp_dr_b), 64'b0110);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_debug_jtag_scan_master.md
Name: cpu_debug_jtag_scan_master

Overview:
- Initiator side of the CPU debug slave's virtual-JTAG interface.
- Runs one IR+DR scan per command, driving tck, tdi, ir_in and the virtual state strobes (uir, cdr, sdr, udr, rti) into the debug slave, and collecting its tdo and ir_out.
- Used for on-chip bring-up and self-test of the debug path without an external JTAG hub.
- Runs entirely in the system clock domain; tck is a divided clock generated as a data signal.

Parameters:
- DR_WIDTH, 38, data register length in bits; matches the slave's sr/jdo width.
- TCK_HALF, 2, clk cycles per tck half-period; legal range >= 1.
- RTI_CYCLES, 1, number of tck periods spent in run-test-idle after update; legal range >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  scan request.
- cmd_ready  out  1  high only in IDLE with no pending response.
- cmd_ir  in  2  IR value to load.
- cmd_dr  in  DR_WIDTH  DR data to shift, LSB first.
- rsp_valid  out  1  scan result available.
- rsp_ready  in  1  result consumed.
- rsp_dr  out  DR_WIDTH  captured tdo bits; bit i = i-th bit shifted out.
- rsp_ir_out  out  2  vji_ir_out sampled during UIR.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  2  IR value presented to slave.
- vji_ir_out  in  2  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

Behaviour:
- Reset:
  - State IDLE.
  - Outputs zero: vji_tck, vji_tdi, all strobes, vji_ir_in, rsp_valid, rsp_dr, rsp_ir_out.
  - cmd_ready is 1 after reset.
- tck period:
  - One period = 2*TCK_HALF clk cycles, driven by a half-period counter.
  - tck is low for the first TCK_HALF cycles and high for the second.
  - Every non-IDLE state lasts an integer number of tck periods.
  - A strobe is high for its whole state.
- Command acceptance:
  - Handshake occurs on cmd_valid && cmd_ready.
  - cmd_dr is latched into a shift register.
  - vji_ir_in <= cmd_ir at the same edge; vji_ir_in holds until the next accepted command.
- State sequence: IDLE -> UIR (1 period) -> CDR (1) -> SDR (DR_WIDTH periods) -> UDR (1) -> RTI (RTI_CYCLES) -> RESP.
- UIR: vji_ir_out is sampled into rsp_ir_out on the clk edge where tck rises.
- SDR, period i:
  - vji_tdi = shift[0], stable for the whole period.
  - On the clk edge where tck rises, vji_tdo is sampled into capture[i].
  - The shift register shifts right at the end of the period.
- SDR exit: after DR_WIDTH periods the bit counter reaches DR_WIDTH-1 and the FSM leaves SDR. There are no extra shifts.
- vji_tdi is 0 outside SDR.
- RESP:
  - rsp_valid = 1, rsp_dr = capture; tck stays low.
  - rsp_dr and rsp_ir_out are stable while rsp_valid is high.
  - rsp_valid clears on rsp_valid && rsp_ready; the FSM returns to IDLE and cmd_ready rises next cycle.
- Latency:
  - Command handshake at cycle 0; UIR begins at cycle 1.
  - rsp_valid rises at cycle 1 + 2*TCK_HALF*(DR_WIDTH+3+RTI_CYCLES).
  - With defaults: 1 + 4*42 = 169.
- Boundaries:
  - A cmd_valid held during a scan is ignored; no queuing.
  - rsp_ready asserted with rsp_valid low has no effect.
  - reset at any cycle, including mid-SDR, returns to IDLE on the next clk edge with the reset values above. The partial capture is discarded and no rsp_valid is produced.
  - reset has priority over a simultaneous command or response handshake.
  - TCK_HALF=1 gives a tck of clk/2; sampling still occurs on the rising-tck cycle.

Test Plan:
- Reset: hold reset 3 cycles -> all outputs 0, cmd_ready=1, vji_tck=0 throughout.
- Loopback model (tdo = tdi delayed by one tck rising edge, initial 0):
  - Stimulus: cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA, defaults.
  - Required: vji_uir high for cycles 1-4, vji_cdr high for 5-8, vji_sdr high for 9-160, vji_udr high for 161-164, vji_rti high for 165-168.
  - Required: rsp_valid at cycle 169 with rsp_dr = {cmd_dr[36:0],1'b0}; vji_ir_in=2'b01 from cycle 1.
- IR status: vji_ir_out=2'b10 during UIR -> rsp_ir_out=2'b10; changing ir_out after UIR has no effect.
- Back-pressure:
  - Stimulus: rsp_ready held low 20 cycles, second cmd_valid asserted meanwhile.
  - Required: cmd_ready=0, rsp_dr stable, no tck toggles.
  - Required: after rsp_ready, the second scan starts 2 cycles after the handshake cycle.
- Reset mid-SDR: assert reset at cycle 50 -> next cycle all strobes 0, tck 0, no rsp_valid; a fresh command then completes normally.
- TCK_HALF=1, DR_WIDTH=4, RTI_CYCLES=2, cmd_dr=4'b1011 -> tdi sequence 1,1,0,1; rsp_valid at cycle 1+2*9=19.
